// File: rtl/des_hash_pkg.sv
// Shared types, constants and byte-mapping helpers for the S-box hash core.
// Holds the FSM state encoding, the chaining-value seed and the S-box table.
package des_hash_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ROUND = 3'd2;
    localparam logic [2:0] S_FINAL = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_LOAD  = S_LOAD,
        ST_ROUND = S_ROUND,
        ST_FINAL = S_FINAL,
        ST_DONE  = S_DONE
    } state_e;

    localparam logic [31:0] H_INIT = 32'h4B71DF03;

    // Row r occupies bits [64r+63:64r]; column c is nibble c within the row.
    localparam logic [255:0] SBOX_TBL = {
        64'h354A90F6D2E17C8B,
        64'hE0365C9F87DAB124,
        64'h6893AF051D74C2BE,
        64'h9E0DF3586BA714C2
    };

    function automatic logic [3:0] sbox(input logic [5:0] x);
        logic [7:0] idx;
        idx = {x[5], x[0], x[4:1], 2'b00};
        return SBOX_TBL[idx +: 4];
    endfunction

    function automatic logic [5:0] m6(input logic [7:0] m);
        return {m[3] ^ m[2], m[1], m[0], m[7], m[6], m[5] ^ m[4]};
    endfunction

    function automatic logic [5:0] c6(input logic [7:0] b);
        return {b[7] ^ b[1], b[3], b[2], b[5] ^ b[0], b[4], b[6]};
    endfunction

    function automatic logic [3:0] rotl4(input logic [3:0] x,
                                         input logic [1:0] r);
        logic [7:0] d;
        d = {x, x} << r;
        return d[7:4];
    endfunction

endpackage

// File: rtl/des_sbox_hash_core_if.sv
// Message-in / digest-out handshake bundle for the S-box hash core.
// master drives the message, slave is the core.
interface des_sbox_hash_core_if #(
    parameter int LEN_W = 64
);
    logic             start;
    logic [LEN_W-1:0] msg_len;
    logic             in_valid;
    logic [7:0]       in_byte;
    logic             in_ready;
    logic             digest_valid;
    logic             digest_ready;
    logic [31:0]      digest;
    logic             busy;

    modport master (
        output start, msg_len, in_valid, in_byte, digest_ready,
        input  in_ready, digest_valid, digest, busy
    );

    modport slave (
        input  start, msg_len, in_valid, in_byte, digest_ready,
        output in_ready, digest_valid, digest, busy
    );
endinterface

// File: rtl/des_hash_round.sv
// One combinational compression round: each nibble takes its upper
// neighbour, mixes in s and rotates by half its index.
module des_hash_round
    import des_hash_pkg::*;
(
    input  logic [3:0]      s_i,
    input  logic [7:0][3:0] h_i,
    output logic [7:0][3:0] h_o
);

    for (genvar i = 0; i < 8; i++) begin : g_nib
        assign h_o[i] = rotl4(h_i[(i + 1) % 8] ^ s_i, 2'(i / 2));
    end

endmodule

// File: rtl/des_sbox_hash_core.sv
// Byte-serial S-box hash with a length-mixing final round.
// Optional DES_HASH_ABORT_EN adds an abort input for LOAD/ROUND.
module des_sbox_hash_core
    import des_hash_pkg::*;
#(
    parameter int NUM_ROUNDS       = 4,
    parameter int ROUNDS_PER_CYCLE = 4,
    parameter int LEN_W            = 64
) (
    input logic clk,
    input logic rst_n,
`ifdef DES_HASH_ABORT_EN
    input logic abort,
`endif
    des_sbox_hash_core_if.slave bus
);

    localparam int RPC = (ROUNDS_PER_CYCLE > 0) ?
                         ROUNDS_PER_CYCLE : 1;
    localparam int CYC = (NUM_ROUNDS / RPC > 0) ?
                         NUM_ROUNDS / RPC : 1;
    localparam logic [4:0] RND_LAST = 5'(CYC - 1);

    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 16) begin : g_bad_nr
        $fatal(1, "NUM_ROUNDS must be 1..16");
    end
    if (ROUNDS_PER_CYCLE < 1 ||
        NUM_ROUNDS % RPC != 0) begin : g_bad_rpc
        $fatal(1, "ROUNDS_PER_CYCLE must divide NUM_ROUNDS");
    end
    if (LEN_W < 8 || LEN_W > 64) begin : g_bad_len
        $fatal(1, "LEN_W must be 8..64");
    end

    state_e           state_q, state_d;
    logic [7:0][3:0]  h_q, h_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [7:0]       byte_q, byte_d;
    logic [4:0]       rnd_q, rnd_d;
    logic [31:0]      dig_q, dig_d;
    logic             abort_w;

`ifdef DES_HASH_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    logic [3:0]      s_w;
    logic [7:0][3:0] chain_w [RPC+1];

    assign s_w        = sbox(m6(byte_q));
    assign chain_w[0] = h_q;

    for (genvar k = 0; k < RPC; k++) begin : g_rnd
        des_hash_round u_round (
            .s_i (s_w),
            .h_i (chain_w[k]),
            .h_o (chain_w[k+1])
        );
    end

    // Final round: every nibble gets its own S-box value, one per length byte.
    logic [63:0]     len64_w;
    logic [7:0][3:0] fin_w;

    assign len64_w = 64'(len_q);

    for (genvar i = 0; i < 8; i++) begin : g_fin
        assign fin_w[i] = rotl4(
            h_q[(i + 1) % 8] ^ sbox(c6(len64_w[8*i +: 8])),
            2'(i / 2));
    end

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        byte_d  = byte_q;
        rnd_d   = rnd_q;
        dig_d   = dig_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    len_d   = bus.msg_len;
                    cnt_d   = bus.msg_len;
                    h_d     = H_INIT;
                    state_d = (bus.msg_len != '0) ?
                              ST_LOAD : ST_FINAL;
                end
            end
            ST_LOAD: begin
                if (abort_w) begin
                    state_d = ST_IDLE;
                end else if (bus.in_valid) begin
                    byte_d  = bus.in_byte;
                    cnt_d   = cnt_q - LEN_W'(1);
                    rnd_d   = '0;
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (abort_w) begin
                    rnd_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    h_d = chain_w[RPC];
                    if (rnd_q == RND_LAST) begin
                        rnd_d   = '0;
                        state_d = (cnt_q != '0) ?
                                  ST_LOAD : ST_FINAL;
                    end else begin
                        rnd_d = rnd_q + 5'd1;
                    end
                end
            end
            ST_FINAL: begin
                dig_d   = fin_w;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.digest_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            h_q     <= H_INIT;
            cnt_q   <= '0;
            len_q   <= '0;
            byte_q  <= '0;
            rnd_q   <= '0;
            dig_q   <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            byte_q  <= byte_d;
            rnd_q   <= rnd_d;
            dig_q   <= dig_d;
        end
    end

    assign bus.in_ready     = (state_q == ST_LOAD);
    assign bus.digest_valid = (state_q == ST_DONE);
    assign bus.digest       = dig_q;
    assign bus.busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_des_sbox_hash_core.sv
// Self-checking bench for des_sbox_hash_core (folded and unfolded builds).
module tb_des_sbox_hash_core;

    localparam int NR = 4;

    logic clk;
    logic rst_n;
    logic abort0;
    logic abort1;

    des_sbox_hash_core_if #(.LEN_W(64)) bus0 ();
    des_sbox_hash_core_if #(.LEN_W(64)) bus1 ();

    des_sbox_hash_core #(
        .NUM_ROUNDS(4), .ROUNDS_PER_CYCLE(4), .LEN_W(64)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef DES_HASH_ABORT_EN
        .abort (abort0),
`endif
        .bus   (bus0)
    );

    des_sbox_hash_core #(
        .NUM_ROUNDS(4), .ROUNDS_PER_CYCLE(1), .LEN_W(64)
    ) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef DES_HASH_ABORT_EN
        .abort (abort1),
`endif
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int hs0[$];
    int hs1[$];

    always @(posedge clk) begin
        if (bus0.in_valid && bus0.in_ready) hs0.push_back(cyc);
        if (bus1.in_valid && bus1.in_ready) hs1.push_back(cyc);
        cyc <= cyc + 1;
    end

    int sb [4][16] = '{
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9},
        '{14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6},
        '{ 4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14},
        '{11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3}
    };

    function automatic int sbx(input int x);
        return sb[((x >> 4) & 2) | (x & 1)][(x >> 1) & 15];
    endfunction

    function automatic int rl(input int v, input int r);
        return ((v << r) | (v >> (4 - r))) & 15;
    endfunction

    function automatic logic [31:0] model(input logic [7:0][7:0] m,
                                          input int n);
        int h [8];
        int t [8];
        int s;
        logic [7:0]  b;
        logic [63:0] lv;
        logic [31:0] d;
        d = 32'h4B71DF03;
        for (int i = 0; i < 8; i++) h[i] = int'(d[4*i +: 4]);
        for (int j = 0; j < n; j++) begin
            b = m[j];
            s = sbx(int'({b[3] ^ b[2], b[1], b[0],
                          b[7], b[6], b[5] ^ b[4]}));
            for (int r = 0; r < NR; r++) begin
                for (int i = 0; i < 8; i++)
                    t[i] = rl(h[(i + 1) % 8] ^ s, i / 2);
                h = t;
            end
        end
        lv = 64'(n);
        for (int i = 0; i < 8; i++) begin
            b = lv[8*i +: 8];
            s = sbx(int'({b[7] ^ b[1], b[3], b[2],
                          b[5] ^ b[0], b[4], b[6]}));
            t[i] = rl(h[(i + 1) % 8] ^ s, i / 2);
        end
        for (int i = 0; i < 8; i++) d[4*i +: 4] = 4'(t[i]);
        return d;
    endfunction

    task automatic chk32(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, got, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic got,
                        input logic exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, got, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out waiting for the DUT", nm);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send0(input logic [7:0][7:0] m, input int n,
                         input int gmax, input int hold,
                         input bit bstart,
                         output logic [31:0] dig);
        int t;
        bit extra;
        extra = 1'b0;
        bus0.start   = 1'b1;
        bus0.msg_len = 64'(n);
        tick();
        bus0.start   = bstart;
        bus0.msg_len = bstart ? 64'd7 : 64'(n);
        for (int j = 0; j < n; j++) begin
            if (gmax > 0) begin
                bus0.in_valid = 1'b0;
                repeat ($urandom_range(0, gmax)) begin
                    bus0.in_byte = 8'($urandom);
                    tick();
                end
            end
            bus0.in_valid = 1'b1;
            bus0.in_byte  = m[j];
            t = 0;
            while (!bus0.in_ready && t < 100) begin
                tick();
                t++;
            end
            if (t >= 100) timeout("in_ready");
            tick();
            bus0.in_byte = 8'($urandom);
        end
        bus0.in_valid = 1'b1;
        t = 0;
        while (!bus0.digest_valid && t < 100) begin
            if (bus0.in_ready) extra = 1'b1;
            tick();
            t++;
        end
        if (t >= 100) timeout("digest_valid");
        chk1("no byte past msg_len", extra, 1'b0);
        dig = bus0.digest;
        repeat (hold) begin
            tick();
            chk1("hold valid", bus0.digest_valid, 1'b1);
            chk32("hold digest", bus0.digest, dig);
        end
        bus0.digest_ready = 1'b1;
        tick();
        bus0.digest_ready = 1'b0;
        bus0.start        = 1'b0;
        bus0.in_valid     = 1'b0;
        chk1("idle after accept", bus0.busy, 1'b0);
    endtask

    task automatic zero_len(input string tag);
        bus0.start   = 1'b1;
        bus0.msg_len = 64'd0;
        tick();
        bus0.start = 1'b0;
        chk1({tag, " busy c1"}, bus0.busy, 1'b1);
        chk1({tag, " valid c1"}, bus0.digest_valid, 1'b0);
        chk1({tag, " ready c1"}, bus0.in_ready, 1'b0);
        tick();
        chk1({tag, " valid c2"}, bus0.digest_valid, 1'b1);
        chk1({tag, " ready c2"}, bus0.in_ready, 1'b0);
        chk32({tag, " digest"}, bus0.digest, 32'h83656FD2);
        bus0.digest_ready = 1'b1;
        tick();
        bus0.digest_ready = 1'b0;
    endtask

    typedef struct {
        int              n;
        logic [7:0][7:0] b;
        int              gmax;
        int              hold;
        bit              bstart;
        logic [31:0]     exp;
    } vec_t;

    vec_t        tbl [8];
    logic [31:0] d0, d1;
    logic [7:0][7:0] msg;
    int          idx0, idx1, t;

    initial begin
        int ns [8] = '{1, 1, 2, 3, 4, 4, 5, 8};
        int gs [8] = '{0, 0, 0, 3, 4, 0, 2, 3};
        int hl [8] = '{0, 2, 0, 5, 10, 0, 1, 0};
        bit bs [8] = '{0, 0, 0, 0, 0, 1, 0, 1};
        rst_n  = 1'b0;
        abort0 = 1'b0;
        abort1 = 1'b0;
        bus0.start = 1'b0; bus0.msg_len = '0;
        bus0.in_valid = 1'b0; bus0.in_byte = '0;
        bus0.digest_ready = 1'b0;
        bus1.start = 1'b0; bus1.msg_len = '0;
        bus1.in_valid = 1'b0; bus1.in_byte = '0;
        bus1.digest_ready = 1'b0;

        repeat (2) tick();
        chk1("reset in_ready", bus0.in_ready, 1'b0);
        chk1("reset digest_valid", bus0.digest_valid, 1'b0);
        chk1("reset busy", bus0.busy, 1'b0);
        chk32("reset digest", bus0.digest, 32'h0);
        chk1("reset busy rpc1", bus1.busy, 1'b0);
        rst_n = 1'b1;

        zero_len("zero length");

        for (int i = 0; i < 8; i++) begin
            tbl[i].n      = ns[i];
            tbl[i].b      = {$urandom, $urandom};
            tbl[i].gmax   = gs[i];
            tbl[i].hold   = hl[i];
            tbl[i].bstart = bs[i];
        end
        tbl[0].b = '0;
        tbl[1].b = '1;
        for (int i = 0; i < 8; i++)
            tbl[i].exp = model(tbl[i].b, tbl[i].n);

        for (int i = 0; i < 8; i++) begin
            send0(tbl[i].b, tbl[i].n, tbl[i].gmax, tbl[i].hold,
                  tbl[i].bstart, d0);
            chk32($sformatf("vector %0d digest", i), d0, tbl[i].exp);
        end

        msg = {$urandom, $urandom};
        send0(msg, 3, 0, 0, 1'b0, d0);
        send0(msg, 3, 4, 10, 1'b0, d1);
        chk32("backpressure vs gap-free", d1, d0);
        chk32("backpressure model", d1, model(msg, 3));

        msg  = {$urandom, $urandom};
        idx0 = hs0.size();
        send0(msg, 5, 0, 0, 1'b0, d0);
        idx1 = hs1.size();
        bus1.start   = 1'b1;
        bus1.msg_len = 64'd5;
        tick();
        bus1.start    = 1'b0;
        bus1.in_valid = 1'b1;
        for (int j = 0; j < 5; j++) begin
            bus1.in_byte = msg[j];
            t = 0;
            while (!bus1.in_ready && t < 100) begin
                tick();
                t++;
            end
            if (t >= 100) timeout("rpc1 in_ready");
            tick();
        end
        bus1.in_valid = 1'b0;
        t = 0;
        while (!bus1.digest_valid && t < 100) begin
            tick();
            t++;
        end
        if (t >= 100) timeout("rpc1 digest_valid");
        d1 = bus1.digest;
        bus1.digest_ready = 1'b1;
        tick();
        bus1.digest_ready = 1'b0;
        chk32("fold rpc1 vs rpc4", d1, d0);
        chk32("fold model", d0, model(msg, 5));
        if (hs0.size() >= idx0 + 5 && hs1.size() >= idx1 + 5) begin
            for (int k = 0; k < 4; k++) begin
                chk32("spacing rpc4",
                      32'(hs0[idx0+k+1] - hs0[idx0+k]), 32'd2);
                chk32("spacing rpc1",
                      32'(hs1[idx1+k+1] - hs1[idx1+k]), 32'd5);
            end
        end else begin
            timeout("handshake count");
        end

        bus0.start   = 1'b1;
        bus0.msg_len = 64'd2;
        tick();
        bus0.start    = 1'b0;
        bus0.in_valid = 1'b1;
        bus0.in_byte  = 8'h5A;
        tick();
        chk1("pre-reset busy", bus0.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("async reset busy", bus0.busy, 1'b0);
        chk32("async reset digest", bus0.digest, 32'h0);
        tick();
        chk1("reset edge in_ready", bus0.in_ready, 1'b0);
        chk1("reset edge valid", bus0.digest_valid, 1'b0);
        chk1("reset edge busy", bus0.busy, 1'b0);
        chk32("reset edge digest", bus0.digest, 32'h0);
        rst_n = 1'b1;
        bus0.in_valid = 1'b0;
        zero_len("after reset");

`ifdef DES_HASH_ABORT_EN
        bus0.start   = 1'b1;
        bus0.msg_len = 64'd4;
        tick();
        bus0.start    = 1'b0;
        bus0.in_valid = 1'b1;
        for (int j = 0; j < 2; j++) begin
            bus0.in_byte = 8'($urandom);
            t = 0;
            while (!bus0.in_ready && t < 100) begin
                tick();
                t++;
            end
            if (t >= 100) timeout("abort in_ready");
            tick();
        end
        abort0 = 1'b1;
        tick();
        abort0 = 1'b0;
        chk1("abort busy", bus0.busy, 1'b0);
        repeat (3) begin
            chk1("abort no valid", bus0.digest_valid, 1'b0);
            tick();
        end
        bus0.start   = 1'b1;
        bus0.msg_len = 64'd2;
        tick();
        bus0.start = 1'b0;
        abort0     = 1'b1;
        tick();
        abort0 = 1'b0;
        chk1("abort over handshake", bus0.busy, 1'b0);
        bus0.in_valid = 1'b0;
        zero_len("after abort");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
